// File: rtl/beep_pkg.sv
// rtl/beep_pkg.sv - shared note codes, FSM states and score-entry layout
//
// Purpose: common definitions for the melody sequencer and its score ROM.
// Ports:   none (package).
package beep_pkg;

   typedef enum logic [2:0] {
      REST = 3'd0, DO, RE, MI, FA, SO, LA, SI
   } note_t;

   typedef enum logic [2:0] {
      IDLE, FETCH, PLAY, GAP, DONE
   } state_t;

   // Score entry: [4:2] note code, [1:0] beats (0 = end of score).
   localparam int ENTRY_W   = 5;
   localparam int CODE_W    = 3;
   localparam int CODE_LSB  = 2;
   localparam int BEATS_W   = 2;
   localparam int BEATS_LSB = 0;

   localparam int IDX_W     = 8;
   localparam int MAX_NOTES = 256;
   localparam int SCORE_W   = MAX_NOTES * ENTRY_W;

   function automatic logic [ENTRY_W-1:0] score_entry(input note_t code,
                                                      input logic [BEATS_W-1:0] beats);
      return {code, beats};
   endfunction

   // Entry 0 sits in the least significant bits; unlisted entries are
   // zero, which doubles as the end-of-score marker.
   localparam logic [SCORE_W-1:0] DEFAULT_SCORE = SCORE_W'({
      score_entry(DO, 2'd2), score_entry(RE, 2'd1), score_entry(RE, 2'd1),
      score_entry(MI, 2'd1), score_entry(MI, 2'd1), score_entry(FA, 2'd1),
      score_entry(FA, 2'd1), score_entry(SO, 2'd2), score_entry(LA, 2'd1),
      score_entry(LA, 2'd1), score_entry(SO, 2'd1), score_entry(SO, 2'd1),
      score_entry(DO, 2'd1), score_entry(DO, 2'd1)
   });

endpackage

// File: rtl/beep_score_rom.sv
// rtl/beep_score_rom.sv - synchronous-read score ROM for the melody sequencer
//
// Purpose: holds NOTE_CNT five-bit note/beats entries, one-cycle read latency.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears read register)
//   addr      - entry index
//   data      - registered entry read from addr on the previous edge
module beep_score_rom
   import beep_pkg::*;
#(
   parameter int                 NOTE_CNT = 48,
   parameter logic [SCORE_W-1:0] SCORE    = DEFAULT_SCORE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [IDX_W-1:0]   addr,
   output logic [ENTRY_W-1:0] data
);

   // Addresses past the score read as the end marker.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         data <= '0;
      else if (int'(addr) < NOTE_CNT)
         data <= SCORE[int'(addr)*ENTRY_W +: ENTRY_W];
      else
         data <= '0;
   end

endmodule

// File: rtl/beep_sequencer.sv
// rtl/beep_sequencer.sv - melody sequencer feeding note codes to the tone generator
//
// Purpose: walks the score ROM, plays each note for beats x TIME_300MS cycles,
//          inserts GAP_CYCLES of silence after each note, optionally loops.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start, stop     - level controls; stop wins, start only acts in IDLE
//   loop_en         - replay from entry 0 instead of finishing
//   note_code       - current note (0 = rest), held through the gap
//   beep_en         - tone enable, high only while a non-rest note plays
//   busy            - high in every state but IDLE
//   done            - one-cycle pulse at the natural end of the score
//   note_idx        - index of the entry being played
module beep_sequencer
   import beep_pkg::*;
#(
   parameter int                 TIME_300MS = 15_000_000,
   parameter int                 GAP_CYCLES = 2_500_000,
   parameter int                 NOTE_CNT   = 48,
   parameter logic [SCORE_W-1:0] SCORE      = DEFAULT_SCORE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   output logic [CODE_W-1:0] note_code,
   output logic              beep_en,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  note_idx
);

   localparam int CYC_W = (TIME_300MS > 1) ? $clog2(TIME_300MS) : 1;
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [CYC_W-1:0] CYC_LOAD = CYC_W'(TIME_300MS - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTE_CNT - 1);

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     idx_nxt;
   logic [CODE_W-1:0]    code_nxt;
   logic [CYC_W-1:0]     cyc_cnt, cyc_nxt;
   logic [BEATS_W-1:0]   beat_cnt, beat_nxt;
   logic [GAP_W-1:0]     gap_cnt, gap_nxt;
   logic                 advance;
   logic [ENTRY_W-1:0]   rom_data;
   logic [CODE_W-1:0]    rom_code;
   logic [BEATS_W-1:0]   rom_beats;

   // The ROM is addressed with the next index so the entry is already
   // registered during the single FETCH cycle.
   beep_score_rom #(
      .NOTE_CNT (NOTE_CNT),
      .SCORE    (SCORE)
   ) u_rom (
      .clk  (clk),
      .rst  (rst),
      .addr (idx_nxt),
      .data (rom_data)
   );

   assign rom_code  = rom_data[CODE_LSB +: CODE_W];
   assign rom_beats = rom_data[BEATS_LSB +: BEATS_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         note_idx  <= '0;
         note_code <= '0;
         cyc_cnt   <= '0;
         beat_cnt  <= '0;
         gap_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         note_idx  <= idx_nxt;
         note_code <= code_nxt;
         cyc_cnt   <= cyc_nxt;
         beat_cnt  <= beat_nxt;
         gap_cnt   <= gap_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = note_idx;
      code_nxt  = note_code;
      cyc_nxt   = cyc_cnt;
      beat_nxt  = beat_cnt;
      gap_nxt   = gap_cnt;
      advance   = 1'b0;

      case (state)
         IDLE: begin
            if (start && !stop) begin
               state_nxt = FETCH;
               idx_nxt   = '0;
            end
         end
         FETCH: begin
            if (rom_beats == '0) begin
               state_nxt = DONE;
            end else begin
               state_nxt = PLAY;
               code_nxt  = rom_code;
               beat_nxt  = rom_beats;
               cyc_nxt   = CYC_LOAD;
            end
         end
         PLAY: begin
            // Each beat counts CYC_LOAD..0; the last beat's zero ends the note.
            if (cyc_cnt != '0) begin
               cyc_nxt = cyc_cnt - 1'b1;
            end else if (beat_cnt != 2'd1) begin
               beat_nxt = beat_cnt - 1'b1;
               cyc_nxt  = CYC_LOAD;
            end else begin
               beat_nxt = '0;
               if (GAP_CYCLES > 0) begin
                  state_nxt = GAP;
                  gap_nxt   = GAP_LOAD;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_cnt != '0)
               gap_nxt = gap_cnt - 1'b1;
            else
               advance = 1'b1;
         end
         DONE: begin
            if (loop_en) begin
               state_nxt = FETCH;
               idx_nxt   = '0;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (advance) begin
         if (note_idx == LAST_IDX) begin
            state_nxt = DONE;
         end else begin
            state_nxt = FETCH;
            idx_nxt   = note_idx + 1'b1;
         end
      end

      if (stop && state != IDLE)
         state_nxt = IDLE;

      // Whatever the route into IDLE, everything visible starts from zero.
      if (state_nxt == IDLE) begin
         idx_nxt  = '0;
         code_nxt = '0;
         cyc_nxt  = '0;
         beat_nxt = '0;
         gap_nxt  = '0;
      end
   end

   assign busy    = (state != IDLE);
   assign beep_en = (state == PLAY) && (note_code != '0);
   assign done    = (state == DONE) && !loop_en && !stop;

endmodule

// File: tb/tb_beep_sequencer.sv
// tb/tb_beep_sequencer.sv - self-checking bench for beep_sequencer
module tb_beep_sequencer;

   localparam int T = 10;
   localparam int G = 2;
   localparam int N = 4;
   localparam logic [1279:0] SC0 = 1280'({5'd13, 5'd31, 5'd2, 5'd5});
   localparam logic [1279:0] SC1 = 1280'({5'd13, 5'd31, 5'd0, 5'd5});

   typedef struct packed {
      logic       keep;
      logic [2:0] code;
      logic       en;
      logic [7:0] idx;
      logic       isd;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic stop = 1'b0;
   logic loop_en = 1'b0;

   logic [2:0] o_code [2];
   logic       o_en   [2];
   logic       o_busy [2];
   logic       o_done [2];
   logic [7:0] o_idx  [2];

   int n_tests = 0;
   int n_fail  = 0;

   int cd [2][4] = '{'{1, 0, 7, 3}, '{1, 0, 7, 3}};
   int bt [2][4] = '{'{1, 2, 3, 1}, '{1, 0, 3, 1}};

   rec_t       tl [2][256];
   bit         m_act [2] = '{0, 0};
   int         m_pos [2] = '{0, 0};
   logic [2:0] m_code [2] = '{3'd0, 3'd0};
   logic       m_en [2] = '{1'b0, 1'b0};
   logic [7:0] m_idx [2] = '{8'd0, 8'd0};
   logic       m_isd [2] = '{1'b0, 1'b0};

   logic [2:0] ec;
   logic       ee, eb, ed;
   logic [7:0] ei;

   logic [2:0] h_code [2][400];
   logic       h_en   [2][400];
   logic       h_busy [2][400];
   logic       h_done [2][400];
   logic [7:0] h_idx  [2][400];

   always #5 clk = ~clk;

   beep_sequencer #(.TIME_300MS(T), .GAP_CYCLES(G), .NOTE_CNT(N), .SCORE(SC0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
      .note_code(o_code[0]), .beep_en(o_en[0]), .busy(o_busy[0]),
      .done(o_done[0]), .note_idx(o_idx[0]));

   beep_sequencer #(.TIME_300MS(T), .GAP_CYCLES(G), .NOTE_CNT(N), .SCORE(SC1)) dut_em (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
      .note_code(o_code[1]), .beep_en(o_en[1]), .busy(o_busy[1]),
      .done(o_done[1]), .note_idx(o_idx[1]));

   // Expand a score into its per-cycle timeline: fetch, play, gap per entry,
   // ending with the DONE cycle. keep=1 means note_code holds its old value.
   task automatic build(input int k);
      int p;
      p = 0;
      for (int i = 0; i < N; i++) begin
         tl[k][p] = '{keep:1'b1, code:3'd0, en:1'b0, idx:8'(i), isd:1'b0}; p++;
         if (bt[k][i] == 0) begin
            tl[k][p] = '{keep:1'b1, code:3'd0, en:1'b0, idx:8'(i), isd:1'b1};
            return;
         end
         for (int b = 0; b < bt[k][i] * T; b++) begin
            tl[k][p] = '{keep:1'b0, code:3'(cd[k][i]), en:(cd[k][i] != 0), idx:8'(i), isd:1'b0}; p++;
         end
         for (int g = 0; g < G; g++) begin
            tl[k][p] = '{keep:1'b0, code:3'(cd[k][i]), en:1'b0, idx:8'(i), isd:1'b0}; p++;
         end
      end
      tl[k][p] = '{keep:1'b1, code:3'd0, en:1'b0, idx:8'(N-1), isd:1'b1};
   endtask

   task automatic apply(input int k);
      rec_t r;
      r = tl[k][m_pos[k]];
      if (!r.keep) m_code[k] = r.code;
      m_en[k]  = r.en;
      m_idx[k] = r.idx;
      m_isd[k] = r.isd;
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst || !m_act[k]) begin
            ec = 3'd0; ee = 1'b0; eb = 1'b0; ed = 1'b0; ei = 8'd0;
         end else begin
            ec = m_code[k]; ee = m_en[k]; eb = 1'b1; ei = m_idx[k];
            ed = m_isd[k] && !loop_en && !stop;
         end
         n_tests++;
         if ({o_code[k], o_en[k], o_busy[k], o_done[k], o_idx[k]} !== {ec, ee, eb, ed, ei}) begin
            n_fail++;
            $display("FAIL model[%0d] t=%0t code=%0d want %0d en=%b want %b busy=%b want %b done=%b want %b idx=%0d want %0d",
                     k, $time, o_code[k], ec, o_en[k], ee, o_busy[k], eb, o_done[k], ed, o_idx[k], ei);
         end
         if (rst) begin
            m_act[k] = 1'b0;
         end else if (!m_act[k]) begin
            if (start && !stop) begin
               m_act[k] = 1'b1; m_pos[k] = 0; m_code[k] = 3'd0; apply(k);
            end
         end else if (stop) begin
            m_act[k] = 1'b0;
         end else if (m_isd[k]) begin
            if (loop_en) begin m_pos[k] = 0; apply(k); end
            else m_act[k] = 1'b0;
         end else begin
            m_pos[k]++; apply(k);
         end
         if (!m_act[k]) begin
            m_code[k] = 3'd0; m_en[k] = 1'b0; m_idx[k] = 8'd0; m_isd[k] = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Cycle c begins just after a rising edge; outputs are recorded mid-cycle.
   task automatic run_script(input int n, input int start_at, input int stop_at);
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         start = (c == start_at);
         stop  = (c == stop_at);
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            h_code[k][c] = o_code[k]; h_en[k][c] = o_en[k]; h_busy[k][c] = o_busy[k];
            h_done[k][c] = o_done[k]; h_idx[k][c] = o_idx[k];
         end
      end
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
   endtask

   function automatic int count_play(input int k, input int n, input int code);
      int s;
      s = 0;
      for (int c = 0; c < n; c++)
         if (h_en[k][c] && h_code[k][c] == 3'(code)) s++;
      return s;
   endfunction

   function automatic int count_done(input int k, input int n);
      int s;
      s = 0;
      for (int c = 0; c < n; c++)
         if (h_done[k][c]) s++;
      return s;
   endfunction

   initial begin
      build(0);
      build(1);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", o_busy[0], 0);
      chk("rst_en",   o_en[0],   0);
      chk("rst_code", o_code[0], 0);
      chk("rst_idx",  o_idx[0],  0);
      chk("rst_done", o_done[0], 0);
      rst = 1'b0;

      // single play
      run_script(100, 0, -1);
      chk("sp_fetch_en",   h_en[0][1], 0);
      chk("sp_do_en_c2",   h_en[0][2], 1);
      chk("sp_do_code_c2", h_code[0][2], 1);
      chk("sp_do_en_c11",  h_en[0][11], 1);
      chk("sp_do_en_c12",  h_en[0][12], 0);
      chk("sp_do_len",     count_play(0, 100, 1), 10);
      chk("sp_rest_code",  h_code[0][20], 0);
      chk("sp_rest_en",    h_en[0][20], 0);
      chk("sp_si_len",     count_play(0, 100, 7), 30);
      chk("sp_mi_len",     count_play(0, 100, 3), 10);
      chk("sp_done_cnt",   count_done(0, 100), 1);
      chk("sp_done_c83",   h_done[0][83], 1);
      chk("sp_busy_c83",   h_busy[0][83], 1);
      chk("sp_busy_c84",   h_busy[0][84], 0);
      chk("em_idx_c14",    h_idx[1][14], 1);
      chk("em_done_c15",   h_done[1][15], 1);
      chk("em_busy_c16",   h_busy[1][16], 0);
      chk("em_no_si",      count_play(1, 100, 7), 0);

      // looping
      loop_en = 1'b1;
      run_script(200, 0, 199);
      chk("lp_done_cnt",  count_done(0, 199), 0);
      chk("lp_idx_c83",   h_idx[0][83], 3);
      chk("lp_busy_c84",  h_busy[0][84], 1);
      chk("lp_idx_c84",   h_idx[0][84], 0);
      chk("lp_code_c85",  h_code[0][85], 1);
      chk("lp_si_c121",   h_code[0][121], 7);
      chk("lp_em_en_c17", h_en[1][17], 1);
      chk("lp_em_done",   count_done(1, 199), 0);
      loop_en = 1'b0;
      run_script(3, -1, -1);

      // stop mid-SI
      run_script(60, 0, 50);
      chk("st_si_c49",   h_code[0][49], 7);
      chk("st_busy_c51", h_busy[0][51], 0);
      chk("st_en_c51",   h_en[0][51], 0);
      chk("st_code_c51", h_code[0][51], 0);
      chk("st_done",     count_done(0, 60), 0);

      // start and stop together in IDLE
      run_script(5, 0, 0);
      chk("ss_busy_c1", h_busy[0][1], 0);
      chk("ss_busy_c2", h_busy[0][2], 0);

      // asynchronous reset mid-note
      run_script(6, 0, -1);
      @(posedge clk); #3;
      chk("ar_pre_en", o_en[0], 1);
      rst = 1'b1;
      #1;
      chk("ar_en",   o_en[0],   0);
      chk("ar_busy", o_busy[0], 0);
      chk("ar_code", o_code[0], 0);
      chk("ar_idx",  o_idx[0],  0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_script(15, 0, -1);
      chk("ar_replay_en",   h_en[0][2], 1);
      chk("ar_replay_code", h_code[0][2], 1);
      chk("ar_replay_idx",  h_idx[0][2], 0);

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         start = ($urandom_range(0, 99) < 6);
         stop  = ($urandom_range(0, 299) < 2);
         if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
         rst   = ($urandom_range(0, 999) < 2);
      end
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0; rst = 1'b0; loop_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/beep_sequencer.md
# beep_sequencer

Melody sequencer that drives the PWM tone generator (`beep`). It steps through a score ROM of note/duration entries, presents one note code at a time to the tone generator, and gates it with `beep_en`. It times each note in 300 ms beats and inserts a silent articulation gap between notes. It sits between top-level control (key or start/stop logic) and the `beep` datapath, which consumes `note_code` and `beep_en`.

## Interface
- `TIME_300MS`, default 15_000_000: clock cycles per beat (300 ms at 50 MHz).
- `GAP_CYCLES`, default 2_500_000: silent cycles after each note; 0 means no gap.
- `NOTE_CNT`, default 48: number of score entries, 1..256.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: level, sampled each cycle; begins playback from entry 0 when idle.
- `stop`  in  1: level; aborts playback.
- `loop_en`  in  1: restart at entry 0 after the last entry instead of finishing.
- `note_code`  out  3: 0 = rest, 1..7 = DO, RE, MI, FA, SO, LA, SI.
- `beep_en`  out  1: tone generator enable.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at natural end of score.
- `note_idx`  out  8: index of the entry currently playing.

## Operation
- ROM entry, 5 bits: `[4:2]` note code, `[1:0]` beats (1..3). A beats value of 0 is the end-of-score marker.
- FSM states: IDLE, FETCH, PLAY, GAP, DONE.
- IDLE: when `start`=1, set address to 0 and go to FETCH.
- FETCH:
  - The 1-cycle ROM read completes.
  - If beats=0, go to DONE.
  - Otherwise latch `note_code` and beats, load the beat counter, and go to PLAY.
- PLAY:
  - Lasts beats×TIME_300MS cycles.
  - `beep_en` = 1 if note_code≠0, else 0.
  - Ends in GAP if GAP_CYCLES>0, otherwise goes straight to the advance step.
- GAP: `beep_en`=0 and `note_code` holds its value. Lasts GAP_CYCLES cycles, then the advance step runs.
- Advance step:
  - If `note_idx`=NOTE_CNT-1, go to DONE.
  - Otherwise increment the index and go to FETCH.
- DONE:
  - If `loop_en`=1: go to FETCH at index 0; `done` is not pulsed.
  - If `loop_en`=0: pulse `done` for one cycle and go to IDLE.
- `stop`=1 in any non-IDLE state: the next state is IDLE, all outputs are cleared, and `done` is not pulsed. `stop` wins over `start` in the same cycle.
- `start` is ignored while busy. A `start` held high in IDLE re-triggers playback; this is intended for auto-replay.
- Counters:
  - Cycle counter width is clog2(TIME_300MS) bits. It counts down and reloads at every beat boundary.
  - Beat counter is 2 bits.
  - Gap counter width is clog2(GAP_CYCLES+1) bits.
  - No counter ever wraps past its load value.

## Timing
- Reset values: state IDLE, `note_code`=0, `beep_en`=0, `busy`=0, `done`=0, `note_idx`=0, all counters 0.
- Start latency: `start` sampled at edge k; FETCH after edge k; PLAY after edge k+1, with `note_code` and `beep_en` valid from that cycle.
- Note period = beats×TIME_300MS + GAP_CYCLES + 1 cycles, including FETCH.
- `beep_en` high time for a non-rest note = exactly beats×TIME_300MS cycles.
- `note_code` changes only on FETCH→PLAY or when entering IDLE.
- `done` asserts in the DONE cycle; `busy` falls on the following edge.
- Asserting `rst` mid-note immediately clears outputs, with no clock needed.

## Structure
- `beep_pkg`:
  - note code constants: REST, DO..SI
  - FSM state encoding
  - ROM entry field widths and offsets
- Sub-module `beep_score_rom`: synchronous-read ROM, NOTE_CNT×5 bits, addressed by `note_idx`. Contents come from a case table or an init file.
- The sequencer FSM and counters live in `beep_sequencer`.

## Test plan
All scenarios use TIME_300MS=10, GAP_CYCLES=2, NOTE_CNT=4, with ROM = {DO/1, REST/2, SI/3, MI/1}.
- Single play, loop_en=0, `start` pulsed at cycle 0:
  - `beep_en` high for cycles 2–11 with code 1.
  - Code 0 with `beep_en` low for 20 cycles.
  - Code 7 for 30 cycles, then code 3 for 10 cycles.
  - `done` pulses once; `busy` drops 1 cycle later.
- loop_en=1: after entry 3, `note_idx` returns to 0 and code 1 replays; `done` never pulses.
- `stop` asserted mid-SI note: next cycle IDLE, `beep_en`=0, `note_code`=0, `busy`=0, `done`=0.
- `start` and `stop` both high in IDLE: state stays IDLE, `busy` stays 0.
- End marker: ROM entry 1 = beats 0 → after DO, DONE is reached, `done` pulses, and entries 2–3 never play.
- Async reset: raise `rst` between clock edges during PLAY → all outputs reach their reset values before the next edge; after release, a new `start` plays from entry 0.
